usb_token_rx: RTL and testbench
===============================

// Module: usb_token_rx
// PURPOSE
//  Receive-side USB token decoder: consumes the de-stuffed, NRZI-decoded serial bit stream of one
//  packet, assembles PID/ADDR/ENDP (or SOF frame number), checks the PID complement and CRC5
//  residual, filters on device address and emits a one-cycle token strobe to the protocol engine.
//  Sits between the bit-level PHY receiver and the device endpoint state machine.
// PARAMETERS
//  ADDR_FILTER  1  1: drop OUT/IN/SETUP whose ADDR != dev_addr; 0: pass all addresses
//  CRC_RESIDUE  5'b01100  required LFSR value after all 16 body bits (incl. inverted CRC5)
// PORTS
//  clk        in   1   single clock
//  rst        in   1   synchronous, active-high reset
//  rx_sop     in   1   pulse: start of packet, precedes first bit
//  rx_bit_vld in   1   rx_bit carries a valid de-stuffed bit this cycle
//  rx_bit     in   1   serial data, LSB of each field first
//  rx_eop     in   1   pulse: end of packet
//  dev_addr   in   7   current device address (sampled at EOP)
//  tok_vld    out  1   pulse: good token decoded
//  tok_pid    out  4   PID[3:0]: 0001 OUT, 1001 IN, 1101 SETUP, 0101 SOF
//  tok_addr   out  7   ADDR field (0 for SOF)
//  tok_endp   out  4   ENDP field (0 for SOF)
//  tok_frame  out  11  SOF frame number (held from last SOF)
//  tok_err    out  1   pulse: malformed token
//  tok_err_code out 2  01 PID check, 10 CRC5, 11 length; valid with tok_err
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, bit counter 0, CRC LFSR 5'b11111.
//  - FSM: IDLE -sop-> PID; PID: shift 8 bits; at 8th bit check pid[7:4]==~pid[3:0]:
//    fail -> DRAIN(err=PID); non-token PID -> IGNORE; token -> BODY (LFSR re-init 5'b11111).
//    BODY: shift 16 bits into body reg and LFSR (poly x^5+x^2+1, serial, LSB first);
//    17th bit -> DRAIN(err=length). EOP in BODY: count!=16 -> err=length; LFSR!=CRC_RESIDUE ->
//    err=CRC; else decode. IGNORE/DRAIN wait for EOP then -> IDLE.
//  - Body mapping: bits[6:0]=ADDR, [10:7]=ENDP, [10:0]=FRAME for SOF, [15:11]=CRC5 (inverted).
//  - Latency: tok_vld / tok_err assert exactly 1 cycle after the rx_eop cycle, for 1 cycle.
//  - Good SOF: tok_vld=1, tok_frame updated, addr/endp=0, no address filter.
//  - Address mismatch with ADDR_FILTER=1: silently dropped, no tok_vld, no tok_err.
//  - tok_pid/addr/endp update only with tok_vld; held otherwise. tok_frame updates only on SOF.
//  - Non-token PIDs (DATA/handshake/special): ignored, no pulse of either kind.
//  - Priority per packet: PID error > length error > CRC error; at most one pulse per packet.
//  - rx_bit_vld and rx_eop same cycle: bit is consumed first, then EOP evaluated.
//  - rx_sop while not IDLE: current packet aborted without any pulse; restart in PID.
//  - rx_eop in IDLE or in PID before 8 bits: length error pulse only if sop was seen, else ignored.
//  - rx_bit_vld in IDLE: ignored. rst mid-packet: return to reset state, no pulse.
// STRUCTURE
//  - Shared package usb_pkg: PID_OUT/IN/SETUP/SOF localparams, token/err code typedefs,
//    CRC5 polynomial and residue constants.
//  - One sub-module: usb_crc5_chk (serial LFSR with init/enable, exposes residue_ok).
//  - Top: FSM, 5-bit bit counter, 8-bit PID and 16-bit body shift registers, output regs.
// TESTING
//  1 SETUP addr0 ep0: bytes 2D 00 10, dev_addr=0 -> tok_vld, pid=1101, addr=0, endp=0.
//  2 Same bytes with last byte 11 -> tok_err, code=10, no tok_vld.
//  3 PID byte 2E (complement bad) then 16 bits -> tok_err, code=01 after EOP.
//  4 IN 69 00 10 with dev_addr=5, ADDR_FILTER=1 -> no pulse; ADDR_FILTER=0 -> tok_vld, pid=1001.
//  5 SETUP truncated to 12 body bits, then 17-bit body -> tok_err code=11 each; DATA0 C3.. -> none.
//  6 sop mid-body then full 2D 00 10 -> exactly one tok_vld; rst mid-body -> no pulse, outputs 0.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB token receiver: PID codes, error codes,
// receive FSM states and the CRC5 generator constants.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;

    // x^5 + x^2 + 1 with the x^5 term implicit in the feedback
    localparam logic [4:0] CRC5_POLY    = 5'b00101;
    localparam logic [4:0] CRC5_INIT    = 5'b11111;
    localparam logic [4:0] CRC5_RESIDUE = 5'b01100;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_PID  = 2'b01,
        ERR_CRC  = 2'b10,
        ERR_LEN  = 2'b11
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PID    = 3'd1,
        ST_BODY   = 3'd2,
        ST_IGNORE = 3'd3,
        ST_DRAIN  = 3'd4
    } rx_state_e;

    function automatic logic is_token_pid(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP) || (pid == PID_SOF);
    endfunction

    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[4];
        return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    endfunction

endpackage

// File: rtl/usb_crc5_chk.sv
// Serial CRC5 checker. o_residue_ok reflects the register after the bit
// offered this cycle, so a final bit arriving together with EOP is included.
module usb_crc5_chk
    import usb_pkg::*;
#(
    parameter logic [4:0] RESIDUE = CRC5_RESIDUE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_init,
    input  logic i_en,
    input  logic i_bit,
    output logic o_residue_ok
);

    logic [4:0] r_crc;
    logic [4:0] w_crc_next;

    assign w_crc_next = crc5_step(r_crc, i_bit);

    // LFSR register: preset on reset/init, advance one bit when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= CRC5_INIT;
        end else if (i_init) begin
            r_crc <= CRC5_INIT;
        end else if (i_en) begin
            r_crc <= w_crc_next;
        end
    end

    assign o_residue_ok = (((i_en && !i_init) ? w_crc_next : r_crc) == RESIDUE);

endmodule

// File: rtl/usb_token_rx.sv
// USB token decoder: assembles PID and 16-bit token body from the de-stuffed
// bit stream, validates PID/length/CRC5 and emits a one-cycle token or error pulse.
module usb_token_rx
    import usb_pkg::*;
#(
    parameter bit         ADDR_FILTER = 1'b1,
    parameter logic [4:0] CRC_RESIDUE = 5'b01100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_sop,
    input  logic        rx_bit_vld,
    input  logic        rx_bit,
    input  logic        rx_eop,
    input  logic [6:0]  dev_addr,
    output logic        tok_vld,
    output logic [3:0]  tok_pid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic [10:0] tok_frame,
    output logic        tok_err,
    output logic [1:0]  tok_err_code
);

    rx_state_e   r_state;
    logic [4:0]  r_cnt;
    logic [7:0]  r_pid;
    logic [15:0] r_body;
    err_code_e   r_err_code;

    logic        r_tok_vld;
    logic [3:0]  r_tok_pid;
    logic [6:0]  r_tok_addr;
    logic [3:0]  r_tok_endp;
    logic [10:0] r_tok_frame;
    logic        r_tok_err;
    err_code_e   r_tok_err_code;

    logic [4:0]  w_cnt_next;
    logic [7:0]  w_pid_next;
    logic [15:0] w_body_next;
    logic [10:0] w_fields;
    logic        w_pid_ok;
    logic        w_pid_done;
    logic        w_body_over;
    logic        w_addr_hit;
    logic        w_crc_init;
    logic        w_crc_en;
    logic        w_residue_ok;

    // Fields arrive LSB first, so new bits enter at the top of each shifter.
    assign w_cnt_next  = r_cnt + {4'd0, rx_bit_vld};
    assign w_pid_next  = {rx_bit, r_pid[7:1]};
    assign w_body_next = {rx_bit, r_body[15:1]};
    assign w_pid_ok    = (w_pid_next[7:4] == ~w_pid_next[3:0]);
    assign w_pid_done  = rx_bit_vld && (r_cnt == 5'd7);
    assign w_body_over = rx_bit_vld && (r_cnt == 5'd16);
    assign w_fields    = rx_bit_vld ? w_body_next[10:0] : r_body[10:0];
    assign w_addr_hit  = !ADDR_FILTER || (w_fields[6:0] == dev_addr);

    assign w_crc_init = rx_sop || (r_state != ST_BODY);
    assign w_crc_en   = rx_bit_vld && (r_state == ST_BODY) && (r_cnt != 5'd16);

    usb_crc5_chk #(
        .RESIDUE (CRC_RESIDUE)
    ) u_crc5 (
        .clk          (clk),
        .rst          (rst),
        .i_init       (w_crc_init),
        .i_en         (w_crc_en),
        .i_bit        (rx_bit),
        .o_residue_ok (w_residue_ok)
    );

    // Packet FSM: shift PID/body bits, classify at EOP, register token/error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 5'd0;
            r_pid          <= 8'h00;
            r_body         <= 16'h0000;
            r_err_code     <= ERR_NONE;
            r_tok_vld      <= 1'b0;
            r_tok_pid      <= 4'h0;
            r_tok_addr     <= 7'h00;
            r_tok_endp     <= 4'h0;
            r_tok_frame    <= 11'h000;
            r_tok_err      <= 1'b0;
            r_tok_err_code <= ERR_NONE;
        end else begin
            r_tok_vld <= 1'b0;
            r_tok_err <= 1'b0;
            if (rx_sop) begin
                // A new SOP silently abandons whatever packet was in flight.
                r_state    <= ST_PID;
                r_cnt      <= 5'd0;
                r_pid      <= 8'h00;
                r_body     <= 16'h0000;
                r_err_code <= ERR_NONE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_PID: begin
                        if (w_pid_done) begin
                            r_pid <= w_pid_next;
                            r_cnt <= 5'd0;
                            if (!w_pid_ok) begin
                                if (rx_eop) begin
                                    r_tok_err      <= 1'b1;
                                    r_tok_err_code <= ERR_PID;
                                    r_state        <= ST_IDLE;
                                end else begin
                                    r_err_code <= ERR_PID;
                                    r_state    <= ST_DRAIN;
                                end
                            end else if (!is_token_pid(w_pid_next[3:0])) begin
                                r_state <= rx_eop ? ST_IDLE : ST_IGNORE;
                            end else if (rx_eop) begin
                                r_tok_err      <= 1'b1;
                                r_tok_err_code <= ERR_LEN;
                                r_state        <= ST_IDLE;
                            end else begin
                                r_state <= ST_BODY;
                            end
                        end else if (rx_eop) begin
                            r_tok_err      <= 1'b1;
                            r_tok_err_code <= ERR_LEN;
                            r_state        <= ST_IDLE;
                        end else if (rx_bit_vld) begin
                            r_pid <= w_pid_next;
                            r_cnt <= w_cnt_next;
                        end
                    end
                    ST_BODY: begin
                        if (w_body_over) begin
                            if (rx_eop) begin
                                r_tok_err      <= 1'b1;
                                r_tok_err_code <= ERR_LEN;
                                r_state        <= ST_IDLE;
                            end else begin
                                r_err_code <= ERR_LEN;
                                r_state    <= ST_DRAIN;
                            end
                        end else begin
                            if (rx_bit_vld) begin
                                r_body <= w_body_next;
                                r_cnt  <= w_cnt_next;
                            end
                            if (rx_eop) begin
                                r_state <= ST_IDLE;
                                if (w_cnt_next != 5'd16) begin
                                    r_tok_err      <= 1'b1;
                                    r_tok_err_code <= ERR_LEN;
                                end else if (!w_residue_ok) begin
                                    r_tok_err      <= 1'b1;
                                    r_tok_err_code <= ERR_CRC;
                                end else if (r_pid[3:0] == PID_SOF) begin
                                    r_tok_vld   <= 1'b1;
                                    r_tok_pid   <= r_pid[3:0];
                                    r_tok_addr  <= 7'h00;
                                    r_tok_endp  <= 4'h0;
                                    r_tok_frame <= w_fields;
                                end else if (w_addr_hit) begin
                                    r_tok_vld  <= 1'b1;
                                    r_tok_pid  <= r_pid[3:0];
                                    r_tok_addr <= w_fields[6:0];
                                    r_tok_endp <= w_fields[10:7];
                                end
                            end
                        end
                    end
                    ST_IGNORE: begin
                        if (rx_eop) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (rx_eop) begin
                            r_tok_err      <= 1'b1;
                            r_tok_err_code <= r_err_code;
                            r_state        <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tok_vld      = r_tok_vld;
    assign tok_pid      = r_tok_pid;
    assign tok_addr     = r_tok_addr;
    assign tok_endp     = r_tok_endp;
    assign tok_frame    = r_tok_frame;
    assign tok_err      = r_tok_err;
    assign tok_err_code = r_tok_err_code;

endmodule

// File: tb/tb_usb_token_rx.sv
// Bench for usb_token_rx: directed token scenarios followed by random packets,
// checked against a packet-level reference model for both address-filter settings.
module tb_usb_token_rx;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [1:0]  code;
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [10:0] frame;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        rx_sop;
    logic        rx_bit_vld;
    logic        rx_bit;
    logic        rx_eop;
    logic [6:0]  dev_addr;

    logic        tok_vld, tok_err;
    logic [3:0]  tok_pid, tok_endp;
    logic [6:0]  tok_addr;
    logic [10:0] tok_frame;
    logic [1:0]  tok_err_code;

    logic        nf_vld, nf_err;
    logic [3:0]  nf_pid, nf_endp;
    logic [6:0]  nf_addr;
    logic [10:0] nf_frame;
    logic [1:0]  nf_err_code;

    int   total;
    int   bad;
    exp_t e_f;
    exp_t e_nf;

    usb_token_rx #(.ADDR_FILTER(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_sop(rx_sop), .rx_bit_vld(rx_bit_vld), .rx_bit(rx_bit),
        .rx_eop(rx_eop), .dev_addr(dev_addr), .tok_vld(tok_vld), .tok_pid(tok_pid),
        .tok_addr(tok_addr), .tok_endp(tok_endp), .tok_frame(tok_frame),
        .tok_err(tok_err), .tok_err_code(tok_err_code)
    );

    usb_token_rx #(.ADDR_FILTER(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .rx_sop(rx_sop), .rx_bit_vld(rx_bit_vld), .rx_bit(rx_bit),
        .rx_eop(rx_eop), .dev_addr(dev_addr), .tok_vld(nf_vld), .tok_pid(nf_pid),
        .tok_addr(nf_addr), .tok_endp(nf_endp), .tok_frame(nf_frame),
        .tok_err(nf_err), .tok_err_code(nf_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inverted CRC5 field as transmitted, from mod-2 long division of the 11 data bits.
    function automatic logic [4:0] crc_field(input logic [10:0] d);
        logic [15:0] v;
        logic [4:0]  f;
        v = 16'h0000;
        for (int i = 0; i < 11; i++) v[15-i] = d[i];
        v[15:11] = ~v[15:11];
        for (int i = 15; i >= 5; i--) begin
            if (v[i]) v[i-:6] = v[i-:6] ^ 6'b100101;
        end
        for (int k = 0; k < 5; k++) f[k] = ~v[4-k];
        return f;
    endfunction

    // Expected result of one whole packet of n bits (bit i = v[i]) after SOP.
    function automatic exp_t model(input exp_t p, input logic [31:0] v, input int n,
                                   input logic [6:0] da, input bit filt);
        exp_t        e;
        logic [7:0]  pid;
        logic [15:0] body;
        e     = p;
        e.vld = 1'b0;
        e.err = 1'b0;
        pid   = v[7:0];
        body  = v[23:8];
        if (n < 8) begin
            e.err = 1'b1; e.code = 2'b11;
        end else if (pid[7:4] != ~pid[3:0]) begin
            e.err = 1'b1; e.code = 2'b01;
        end else if (!(pid[3:0] inside {4'b0001, 4'b1001, 4'b1101, 4'b0101})) begin
            e.err = 1'b0;
        end else if (n != 24) begin
            e.err = 1'b1; e.code = 2'b11;
        end else if (body[15:11] != crc_field(body[10:0])) begin
            e.err = 1'b1; e.code = 2'b10;
        end else if (pid[3:0] == 4'b0101) begin
            e.vld = 1'b1; e.pid = pid[3:0]; e.addr = 7'h00; e.endp = 4'h0; e.frame = body[10:0];
        end else if (filt && (body[6:0] != da)) begin
            e.vld = 1'b0;
        end else begin
            e.vld = 1'b1; e.pid = pid[3:0]; e.addr = body[6:0]; e.endp = body[10:7];
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic bv, input logic b, input logic e);
        rx_sop = s; rx_bit_vld = bv; rx_bit = b; rx_eop = e;
        @(posedge clk);
        #1;
        rx_sop = 1'b0; rx_bit_vld = 1'b0; rx_bit = 1'b0; rx_eop = 1'b0;
    endtask

    task automatic quiet(input string tag);
        check({tag, "_quiet"}, 32'({tok_vld, tok_err, nf_vld, nf_err}), 32'(4'b0000));
    endtask

    task automatic check_pkt(input string tag);
        check({tag, "_vld"},   32'(tok_vld),   32'(e_f.vld));
        check({tag, "_err"},   32'(tok_err),   32'(e_f.err));
        if (e_f.err) check({tag, "_code"}, 32'(tok_err_code), 32'(e_f.code));
        check({tag, "_pid"},   32'(tok_pid),   32'(e_f.pid));
        check({tag, "_addr"},  32'(tok_addr),  32'(e_f.addr));
        check({tag, "_endp"},  32'(tok_endp),  32'(e_f.endp));
        check({tag, "_frame"}, 32'(tok_frame), 32'(e_f.frame));
        check({tag, "_nf_vld"},   32'(nf_vld),   32'(e_nf.vld));
        check({tag, "_nf_err"},   32'(nf_err),   32'(e_nf.err));
        if (e_nf.err) check({tag, "_nf_code"}, 32'(nf_err_code), 32'(e_nf.code));
        check({tag, "_nf_pid"},   32'(nf_pid),   32'(e_nf.pid));
        check({tag, "_nf_addr"},  32'(nf_addr),  32'(e_nf.addr));
        check({tag, "_nf_endp"},  32'(nf_endp),  32'(e_nf.endp));
        check({tag, "_nf_frame"}, 32'(nf_frame), 32'(e_nf.frame));
    endtask

    task automatic partial(input string tag, input logic [31:0] v, input int n);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        quiet(tag);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, v[i], 1'b0);
            quiet(tag);
        end
    endtask

    task automatic packet(input string tag, input logic [31:0] v, input int n,
                          input bit gaps, input bit eop_last);
        bit last;
        e_f  = model(e_f,  v, n, dev_addr, 1'b1);
        e_nf = model(e_nf, v, n, dev_addr, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        quiet(tag);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                cyc(1'b0, 1'b0, 1'($urandom), 1'b0);
                quiet(tag);
            end
            last = eop_last && (i == n - 1);
            cyc(1'b0, 1'b1, v[i], last);
            if (!last) quiet(tag);
        end
        if (!(eop_last && (n > 0))) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_pkt(tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        quiet({tag, "_after"});
    endtask

    initial begin
        logic [3:0]  tk [4];
        logic [3:0]  nt [12];
        logic [31:0] v;
        logic [15:0] body;
        logic [10:0] d11;
        logic [7:0]  pid8;
        logic [3:0]  p4;
        logic [6:0]  addr;
        int          n;
        int          kind;
        int          nb;

        tk = '{4'b0001, 4'b1001, 4'b1101, 4'b0101};
        nt = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};
        total = 0; bad = 0;
        e_f = '0; e_nf = '0;
        rst = 1'b1; rx_sop = 1'b0; rx_bit_vld = 1'b0; rx_bit = 1'b0; rx_eop = 1'b0;
        dev_addr = 7'd0;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_ctl",   32'({tok_vld, tok_err, tok_err_code, tok_pid}), 32'(0));
        check("reset_addr",  32'({tok_addr, tok_endp}), 32'(0));
        check("reset_frame", 32'(tok_frame), 32'(0));
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Directed scenarios
        packet("t1_setup", {8'h00, 8'h10, 8'h00, 8'h2D}, 24, 1'b0, 1'b0);
        check("t1_pid_const", 32'(tok_pid), 32'(4'b1101));
        packet("t2_crc",   {8'h00, 8'h11, 8'h00, 8'h2D}, 24, 1'b0, 1'b0);
        packet("t3_pid",   {8'h00, 8'h10, 8'h00, 8'h2E}, 24, 1'b0, 1'b0);
        dev_addr = 7'd5;
        packet("t4_in",    {8'h00, 8'h10, 8'h00, 8'h69}, 24, 1'b0, 1'b0);
        check("t4_filt_pid_held", 32'(tok_pid), 32'(4'b1101));
        check("t4_nofilt_pid",    32'(nf_pid),  32'(4'b1001));
        dev_addr = 7'd0;
        packet("t5_short", {8'h00, 8'h10, 8'h00, 8'h2D}, 20, 1'b0, 1'b0);
        packet("t5_long",  {8'h01, 8'h10, 8'h00, 8'h2D}, 25, 1'b0, 1'b0);
        packet("t5_data0", {8'hAA, 8'h55, 8'h12, 8'hC3}, 32, 1'b0, 1'b0);
        packet("t5_pidonly", {8'h00, 8'h10, 8'h00, 8'h2D}, 8, 1'b0, 1'b1);
        d11 = 11'h2AB;
        packet("t_sof", {8'h00, crc_field(d11), d11, 8'hA5}, 24, 1'b0, 1'b1);
        check("t_sof_frame_const", 32'(tok_frame), 32'(11'h2AB));
        partial("t6_abort_part", {8'h00, 8'h10, 8'h00, 8'h2D}, 14);
        packet("t6_abort", {8'h00, 8'h10, 8'h00, 8'h2D}, 24, 1'b0, 1'b0);
        partial("t6_rst_part", {8'h00, 8'h10, 8'h00, 8'h2D}, 13);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        e_f = '0; e_nf = '0;
        check("t6_rst_ctl",   32'({tok_vld, tok_err, tok_err_code, tok_pid}), 32'(0));
        check("t6_rst_addr",  32'({tok_addr, tok_endp}), 32'(0));
        check("t6_rst_frame", 32'({tok_frame, nf_frame}), 32'(0));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        quiet("t6_eop_idle");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        quiet("t6_eop_idle2");

        // Random packets
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 3)) begin
                cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0);
                quiet("rnd_idle");
            end
            kind = $urandom_range(0, 9);
            p4   = tk[$urandom_range(0, 3)];
            addr = 7'($urandom);
            d11  = (p4 == 4'b0101) ? 11'($urandom) : {4'($urandom), addr};
            body = {crc_field(d11), d11};
            pid8 = {~p4, p4};
            n    = 24;
            case (kind)
                0: body[15:11] = body[15:11] ^ 5'($urandom_range(1, 31));
                1: pid8[7:4] = pid8[7:4] ^ 4'($urandom_range(1, 15));
                2: begin
                    p4   = nt[$urandom_range(0, 11)];
                    pid8 = {~p4, p4};
                end
                3: begin
                    nb = $urandom_range(0, 20);
                    if (nb == 16) nb = 17;
                    n = 8 + nb;
                end
                4: n = $urandom_range(0, 7);
                default: n = 24;
            endcase
            v = {8'($urandom), body, pid8};
            dev_addr = ($urandom_range(0, 1) == 1) ? d11[6:0] : 7'($urandom);
            packet("rnd", v, n, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
